// File: rtl/rv32_data_mem_controller.sv
`timescale 1ns/1ps
// rv32_data_mem_controller
//   Memory-stage data-bus master sitting directly behind the load/store unit.
//   Takes one memory_request_t at a time, drives a word-wide valid/ready bus,
//   and returns aligned, sign/zero-extended load data with request_done.
//   Misaligned accesses complete without touching the bus; bus stalls longer
//   than TIMEOUT_CYCLES abort with bus_fault so the pipeline never hangs.
//
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   data_request      addr / op / store data from the LSU (sampled in IDLE only)
//   hold              downstream stall; keeps the completed result presented
//   request_done      access complete; load_data and flags valid this cycle
//   load_data         extended load result (0 for stores and faults)
//   misaligned        with request_done: not naturally aligned, nothing issued
//   bus_fault         with request_done: timeout abort
//   bus_valid/ready   request handshake
//   bus_we, bus_addr, bus_be, bus_wdata   request payload
//   bus_rvalid, bus_rdata                 read response
//   dbg_state         current FSM state (0 IDLE, 1 REQ, 2 RESP, 3 DONE)
//
// Handshake: a request is transferred on a rising edge where bus_valid and
// bus_ready are both 1. While bus_valid=1 and bus_ready=0 every request field
// holds steady. bus_valid never drops without a transfer, except on timeout
// abort or reset. Read data is taken only in RESP, on the first edge with
// bus_rvalid=1; rvalid at any other time is ignored.

package rv32_dmem_pkg;
  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op;

  typedef struct packed {
    logic [31:0] addr;
    mem_op       op;
    logic [31:0] data;
  } memory_request_t;
endpackage

module rv32_data_mem_controller
  import rv32_dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  memory_request_t data_request,
  input  logic            hold,
  output logic            request_done,
  output logic [31:0]     load_data,
  output logic            misaligned,
  output logic            bus_fault,
  output logic            bus_valid,
  input  logic            bus_ready,
  output logic            bus_we,
  output logic [31:0]     bus_addr,
  output logic [3:0]      bus_be,
  output logic [31:0]     bus_wdata,
  input  logic            bus_rvalid,
  input  logic [31:0]     bus_rdata,
  output logic [1:0]      dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

  state_e             state_q, state_d;
  mem_op              op_q, op_d;
  logic [1:0]         addr_lo_q, addr_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               request_done_q, request_done_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               misaligned_q, misaligned_d;
  logic               bus_fault_q, bus_fault_d;
  logic               bus_valid_q, bus_valid_d;
  logic               bus_we_q, bus_we_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [3:0]         bus_be_q, bus_be_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;

  // Decode of the incoming request (only acted on in IDLE).
  logic        req_store;
  logic        req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  always_comb begin
    req_store      = data_request.op inside {MEM_SB, MEM_SH, MEM_SW};
    req_misaligned = 1'b0;
    req_be         = 4'b0001 << data_request.addr[1:0];
    req_wdata      = {4{data_request.data[7:0]}};
    case (data_request.op)
      MEM_LH, MEM_LHU, MEM_SH: begin
        req_misaligned = data_request.addr[0];
        req_be         = data_request.addr[1] ? 4'b1100 : 4'b0011;
        req_wdata      = {2{data_request.data[15:0]}};
      end
      MEM_LW, MEM_SW: begin
        req_misaligned = |data_request.addr[1:0];
        req_be         = 4'b1111;
        req_wdata      = data_request.data;
      end
      default: ;
    endcase
  end

  // Move the addressed byte/half down to bit 0, then extend by op.
  logic [31:0] lane;
  logic [31:0] load_ext;

  always_comb begin
    lane = bus_rdata >> {addr_lo_q, 3'b000};
    case (op_q)
      MEM_LB:  load_ext = {{24{lane[7]}}, lane[7:0]};
      MEM_LBU: load_ext = {24'h0, lane[7:0]};
      MEM_LH:  load_ext = {{16{lane[15]}}, lane[15:0]};
      MEM_LHU: load_ext = {16'h0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_expired;

  always_comb begin
    cnt_inc     = cnt_q + CNT_W'(1);
    cnt_expired = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    state_d        = state_q;
    op_d           = op_q;
    addr_lo_d      = addr_lo_q;
    cnt_d          = cnt_q;
    request_done_d = request_done_q;
    load_data_d    = load_data_q;
    misaligned_d   = misaligned_q;
    bus_fault_d    = bus_fault_q;
    bus_valid_d    = bus_valid_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_be_d       = bus_be_q;
    bus_wdata_d    = bus_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (data_request.op != MEM_NOP) begin
          op_d      = data_request.op;
          addr_lo_d = data_request.addr[1:0];
          if (req_misaligned) begin
            state_d        = S_DONE;
            request_done_d = 1'b1;
            misaligned_d   = 1'b1;
            load_data_d    = 32'h0;
          end else begin
            state_d     = S_REQ;
            cnt_d       = '0;
            bus_valid_d = 1'b1;
            bus_we_d    = req_store;
            bus_addr_d  = {data_request.addr[31:2], 2'b00};
            bus_be_d    = req_be;
            bus_wdata_d = req_wdata;
          end
        end
      end

      S_REQ: begin
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          if (bus_we_q) begin
            state_d        = S_DONE;
            request_done_d = 1'b1;
            load_data_d    = 32'h0;
          end else begin
            state_d = S_RESP;
            cnt_d   = '0;
          end
        end else if (cnt_expired) begin
          state_d        = S_DONE;
          bus_valid_d    = 1'b0;
          request_done_d = 1'b1;
          bus_fault_d    = 1'b1;
          load_data_d    = 32'h0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RESP: begin
        if (bus_rvalid) begin
          state_d        = S_DONE;
          request_done_d = 1'b1;
          load_data_d    = load_ext;
        end else if (cnt_expired) begin
          state_d        = S_DONE;
          request_done_d = 1'b1;
          bus_fault_d    = 1'b1;
          load_data_d    = 32'h0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DONE: begin
        // Result stays presented while the pipeline is held; never reissued.
        if (!hold) begin
          state_d        = S_IDLE;
          request_done_d = 1'b0;
          misaligned_d   = 1'b0;
          bus_fault_d    = 1'b0;
          load_data_d    = 32'h0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= MEM_NOP;
      addr_lo_q      <= 2'b00;
      cnt_q          <= '0;
      request_done_q <= 1'b0;
      load_data_q    <= 32'h0;
      misaligned_q   <= 1'b0;
      bus_fault_q    <= 1'b0;
      bus_valid_q    <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= 32'h0;
      bus_be_q       <= 4'h0;
      bus_wdata_q    <= 32'h0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_lo_q      <= addr_lo_d;
      cnt_q          <= cnt_d;
      request_done_q <= request_done_d;
      load_data_q    <= load_data_d;
      misaligned_q   <= misaligned_d;
      bus_fault_q    <= bus_fault_d;
      bus_valid_q    <= bus_valid_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_be_q       <= bus_be_d;
      bus_wdata_q    <= bus_wdata_d;
    end
  end

  assign request_done = request_done_q;
  assign load_data    = load_data_q;
  assign misaligned   = misaligned_q;
  assign bus_fault    = bus_fault_q;
  assign bus_valid    = bus_valid_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_be       = bus_be_q;
  assign bus_wdata    = bus_wdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rv32_data_mem_controller.sv
`timescale 1ns/1ps
module tb_rv32_data_mem_controller;
  import rv32_dmem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_request_t data_request;
  logic        hold = 1'b0;
  logic        request_done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_fault;
  logic        bus_valid;
  logic        bus_ready = 1'b1;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata  = 32'h0;
  logic [1:0]  dbg_state;

  rv32_data_mem_controller #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .data_request(data_request), .hold(hold),
    .request_done(request_done), .load_data(load_data),
    .misaligned(misaligned), .bus_fault(bus_fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- bus slave model ----------------
  // Counts accepts; for reads, returns rsp_word one cycle after the accept.
  logic        auto_rsp = 1'b1;
  logic [31:0] rsp_word = 32'h0;
  int          acc_cnt  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus_valid && bus_ready) begin
        acc_cnt++;
        if (!bus_we && auto_rsp) begin
          @(posedge clk);
          #1;
          bus_rvalid = 1'b1;
          bus_rdata  = rsp_word;
          @(posedge clk);
          #1;
          bus_rvalid = 1'b0;
          bus_rdata  = 32'h0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input mem_op op, input logic [31:0] addr, input logic [31:0] data);
    data_request.addr = addr;
    data_request.op   = op;
    data_request.data = data;
    step();
    // Scribble the request afterwards; the latched copy must be used.
    data_request.op   = MEM_NOP;
    data_request.addr = 32'h0BAD_0BAD;
    data_request.data = 32'h5555_5555;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!request_done && cyc < 400) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_access(input string tag, input mem_op op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rsp,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic exp_we, input logic [31:0] exp_wdata,
                            input int exp_lat, input logic [31:0] exp_load);
    int cyc;
    int acc0;
    rsp_word = rsp;
    acc0     = acc_cnt;
    issue(op, addr, data);
    check_eq({tag, "_valid"}, 32'(bus_valid), 32'd1);
    check_eq({tag, "_we"},    32'(bus_we),    32'(exp_we));
    check_eq({tag, "_addr"},  bus_addr,       exp_addr);
    check_eq({tag, "_be"},    32'(bus_be),    32'(exp_be));
    if (exp_we) check_eq({tag, "_wdata"}, bus_wdata, exp_wdata);
    wait_done(cyc);
    check_eq({tag, "_done"},    32'(request_done), 32'd1);
    check_eq({tag, "_latency"}, 32'(cyc),          32'(exp_lat));
    check_eq({tag, "_load"},    load_data,         exp_load);
    check_eq({tag, "_flags"},   {30'h0, misaligned, bus_fault}, 32'h0);
    check_eq({tag, "_accepts"}, 32'(acc_cnt - acc0), 32'd1);
    step();
    check_eq({tag, "_done_clr"}, 32'(request_done), 32'd0);
  endtask

  task automatic run_misaligned(input string tag, input mem_op op, input logic [31:0] addr);
    int acc0;
    acc0 = acc_cnt;
    issue(op, addr, 32'hA5A5_A5A5);
    check_eq({tag, "_done"},  32'(request_done), 32'd1);
    check_eq({tag, "_mis"},   32'(misaligned),   32'd1);
    check_eq({tag, "_fault"}, 32'(bus_fault),    32'd0);
    check_eq({tag, "_valid"}, 32'(bus_valid),    32'd0);
    check_eq({tag, "_load"},  load_data,         32'h0);
    step();
    check_eq({tag, "_clr"},     {30'h0, request_done, misaligned}, 32'h0);
    check_eq({tag, "_accepts"}, 32'(acc_cnt - acc0), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int vcnt;
    int acc0;

    data_request.addr = 32'h0;
    data_request.op   = MEM_NOP;
    data_request.data = 32'h0;

    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset values
    check_eq("rst_done",  32'(request_done), 32'd0);
    check_eq("rst_flags", {30'h0, misaligned, bus_fault}, 32'h0);
    check_eq("rst_valid", 32'(bus_valid), 32'd0);
    check_eq("rst_we",    32'(bus_we),    32'd0);
    check_eq("rst_addr",  bus_addr,       32'h0);
    check_eq("rst_be",    32'(bus_be),    32'h0);
    check_eq("rst_wdata", bus_wdata,      32'h0);
    check_eq("rst_load",  load_data,      32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // NOP held for a few cycles: no bus activity
    acc0 = acc_cnt;
    repeat (4) step();
    check_eq("nop_valid",   32'(bus_valid), 32'd0);
    check_eq("nop_state",   32'(dbg_state), 32'd0);
    check_eq("nop_accepts", 32'(acc_cnt - acc0), 32'd0);

    // Stores (exp_load 0, latency 2)
    run_access("sw",  MEM_SW, 32'h100, 32'hDEADBEEF, 32'h0, 32'h100, 4'b1111, 1'b1, 32'hDEADBEEF, 2, 32'h0);
    run_access("sb",  MEM_SB, 32'h101, 32'h000000AB, 32'h0, 32'h100, 4'b0010, 1'b1, 32'hABABABAB, 2, 32'h0);
    run_access("sb3", MEM_SB, 32'h107, 32'h12345678, 32'h0, 32'h104, 4'b1000, 1'b1, 32'h78787878, 2, 32'h0);
    run_access("sh",  MEM_SH, 32'h202, 32'h00001234, 32'h0, 32'h200, 4'b1100, 1'b1, 32'h12341234, 2, 32'h0);

    // Loads (latency 3)
    run_access("lb",   MEM_LB,  32'h103, 32'h0, 32'h80112233, 32'h100, 4'b1000, 1'b0, 32'h0, 3, 32'hFFFFFF80);
    run_access("lbu",  MEM_LBU, 32'h103, 32'h0, 32'h80112233, 32'h100, 4'b1000, 1'b0, 32'h0, 3, 32'h00000080);
    run_access("lb1",  MEM_LB,  32'h101, 32'h0, 32'h00007F00, 32'h100, 4'b0010, 1'b0, 32'h0, 3, 32'h0000007F);
    run_access("lh",   MEM_LH,  32'h102, 32'h0, 32'h80017FFF, 32'h100, 4'b1100, 1'b0, 32'h0, 3, 32'hFFFF8001);
    run_access("lhu",  MEM_LHU, 32'h102, 32'h0, 32'h80017FFF, 32'h100, 4'b1100, 1'b0, 32'h0, 3, 32'h00008001);
    run_access("lh0",  MEM_LH,  32'h100, 32'h0, 32'h80017FFF, 32'h100, 4'b0011, 1'b0, 32'h0, 3, 32'h00007FFF);
    run_access("lw",   MEM_LW,  32'h104, 32'h0, 32'h11223344, 32'h104, 4'b1111, 1'b0, 32'h0, 3, 32'h11223344);

    // Misaligned: done one cycle after issue, never on the bus
    run_misaligned("mis_lh", MEM_LH, 32'h201);
    run_misaligned("mis_lw", MEM_LW, 32'h102);
    run_misaligned("mis_sw", MEM_SW, 32'h203);
    run_misaligned("mis_sh", MEM_SH, 32'h105);

    // Timeout: bus_ready held low; exactly 255 bus_valid cycles then fault
    bus_ready = 1'b0;
    acc0 = acc_cnt;
    issue(MEM_LW, 32'h300, 32'h0);
    vcnt = 0;
    cyc  = 1;
    while (!request_done && cyc < 400) begin
      if (bus_valid) vcnt++;
      step();
      cyc++;
    end
    check_eq("to_done",    32'(request_done), 32'd1);
    check_eq("to_fault",   32'(bus_fault),    32'd1);
    check_eq("to_mis",     32'(misaligned),   32'd0);
    check_eq("to_load",    load_data,         32'h0);
    check_eq("to_valid",   32'(bus_valid),    32'd0);
    check_eq("to_vcycles", 32'(vcnt),         32'd255);
    check_eq("to_latency", 32'(cyc),          32'd256);
    bus_ready = 1'b1;
    step();
    check_eq("to_clr",     {29'h0, request_done, bus_fault, bus_valid}, 32'h0);
    check_eq("to_accepts", 32'(acc_cnt - acc0), 32'd0);

    // Hold: done result stays presented for 4 cycles, single accept
    hold = 1'b1;
    rsp_word = 32'hCAFEF00D;
    acc0 = acc_cnt;
    issue(MEM_LW, 32'h400, 32'h0);
    wait_done(cyc);
    check_eq("hold_latency", 32'(cyc), 32'd3);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("hold_done_%0d", i),  32'(request_done), 32'd1);
      check_eq($sformatf("hold_load_%0d", i),  load_data,         32'hCAFEF00D);
      check_eq($sformatf("hold_valid_%0d", i), 32'(bus_valid),    32'd0);
      if (i < 3) step();
    end
    hold = 1'b0;
    step();
    check_eq("hold_release", 32'(request_done), 32'd0);
    check_eq("hold_load_clr", load_data,        32'h0);
    check_eq("hold_accepts", 32'(acc_cnt - acc0), 32'd1);

    // Reset while waiting in RESP; late rvalid must be dropped
    auto_rsp = 1'b0;
    issue(MEM_LW, 32'h500, 32'h0);
    step();
    check_eq("rr_in_resp", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h12345678;
    step();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    check_eq("rr_done",  32'(request_done), 32'd0);
    check_eq("rr_load",  load_data,         32'h0);
    check_eq("rr_valid", 32'(bus_valid),    32'd0);
    check_eq("rr_addr",  bus_addr,          32'h0);
    check_eq("rr_state", 32'(dbg_state),    32'd0);
    step();
    check_eq("rr_done2", 32'(request_done), 32'd0);
    auto_rsp = 1'b1;

    // Recovery after reset
    run_access("post_sw", MEM_SW, 32'h600, 32'h0BADCAFE, 32'h0, 32'h600, 4'b1111, 1'b1, 32'h0BADCAFE, 2, 32'h0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
